host_spi_master: RTL and testbench

Single-clock SPI master (mode 0, MSB first) that shifts one fixed-length command frame out to the reversible PE's SPI slave and captures the slave's reply. It sits on the FPGA/host side of the link. A frame is started by a one-cycle request, and the block reports completion, plus read data for read frames, with single-cycle pulses.

---
 rtl/host_spi_master_pkg.sv | 13 +
 rtl/host_spi_master.sv | 138 +++++++++++++
 tb/tb_host_spi_master.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/host_spi_master_pkg.sv
// Shared SPI link definitions for the host-side master and the PE-side slave.
// Holds the field widths, the derived frame width and the command encodings.
// Frame layout on the wire, MSB first: {cmd[1:0], addr, 1'b0, data}.
package host_spi_master_pkg;

  localparam int unsigned SPI_DATA_WIDTH  = 18;
  localparam int unsigned SPI_ADDR_WIDTH  = 6;
  localparam int unsigned SPI_FRAME_WIDTH = SPI_DATA_WIDTH + SPI_ADDR_WIDTH + 3;

  localparam logic [1:0] CMD_WR = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b01;

endpackage

// File: rtl/host_spi_master.sv
// Host-side SPI master, mode 0, MSB first. Shifts one DW-bit command frame out
// on a one-cycle start request and captures the slave's reply. The last RX
// reply bits are returned as read data on read frames.
//
// Ports:
//   clk, rst          sole clock, synchronous active-high reset
//   spi_start         frame request, sampled only while idle
//   spi_tx_data       frame to send, latched when the request is accepted
//   spi_complete      one-cycle pulse at the end of every frame
//   spi_rx_data       read data, held between read frames
//   spi_rx_valid      one-cycle pulse with spi_complete on read frames only
//   spi_sck/csn/mosi  SPI outputs (sck idles low, csn active low)
//   spi_miso          serial data from the slave
module host_spi_master
  import host_spi_master_pkg::*;
#(
  parameter int unsigned DW = SPI_FRAME_WIDTH,
  parameter int unsigned RX = SPI_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_start,
  input  logic [DW-1:0] spi_tx_data,
  output logic          spi_complete,
  output logic [RX-1:0] spi_rx_data,
  output logic          spi_rx_valid,
  output logic          spi_sck,
  output logic          spi_csn,
  output logic          spi_mosi,
  input  logic          spi_miso
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [2:0] {StIdle, StSetup, StSckHi, StSckLo, StDone} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] tx_q, tx_d;
  logic [RX-1:0] rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [RX-1:0] rx_data_q, rx_data_d;
  logic          sck_q, sck_d;
  logic          csn_q, csn_d;
  logic          mosi_q, mosi_d;
  logic          complete_q, complete_d;
  logic          rx_valid_q, rx_valid_d;
  logic          last_bit;

  assign last_bit = (cnt_q == CW'(DW - 1));

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    rx_data_d  = rx_data_q;
    complete_d = 1'b0;
    rx_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (spi_start) begin
          tx_d    = spi_tx_data;
          cmd_d   = spi_tx_data[DW-1 -: 2];
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: state_d = StSckHi;
      StSckHi: begin
        // Capture on the rising edge; shifting tx here puts the next bit on
        // mosi as sck falls, keeping mosi stable around every rising edge.
        rx_d    = {rx_q[RX-2:0], spi_miso};
        tx_d    = {tx_q[DW-2:0], 1'b0};
        state_d = StSckLo;
      end
      StSckLo: begin
        if (last_bit) begin
          state_d    = StDone;
          complete_d = 1'b1;
          if (cmd_q == CMD_RD) begin
            rx_data_d  = rx_q;
            rx_valid_d = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = StSckHi;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Pin values are decoded from the next state and registered, so the SPI
    // outputs come straight from flops and cannot glitch.
    csn_d  = (state_d == StIdle) || (state_d == StDone);
    sck_d  = (state_d == StSckHi);
    mosi_d = (state_d inside {StSetup, StSckHi, StSckLo}) ? tx_d[DW-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_q       <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      rx_data_q  <= '0;
      sck_q      <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
      complete_q <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      rx_data_q  <= rx_data_d;
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      mosi_q     <= mosi_d;
      complete_q <= complete_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign spi_sck      = sck_q;
  assign spi_csn      = csn_q;
  assign spi_mosi     = mosi_q;
  assign spi_complete = complete_q;
  assign spi_rx_valid = rx_valid_q;
  assign spi_rx_data  = rx_data_q;

endmodule

// File: tb/tb_host_spi_master.sv
// Directed bench for host_spi_master with a mode-0 slave model that drives a
// reply frame MSB first, changing miso on falling sck.
module tb_host_spi_master;
  import host_spi_master_pkg::*;

  localparam int unsigned DW = SPI_FRAME_WIDTH;
  localparam int unsigned RX = SPI_DATA_WIDTH;

  logic          clk;
  logic          rst;
  logic          spi_start;
  logic [DW-1:0] spi_tx_data;
  logic          spi_complete;
  logic [RX-1:0] spi_rx_data;
  logic          spi_rx_valid;
  logic          spi_sck;
  logic          spi_csn;
  logic          spi_mosi;
  logic          spi_miso;

  host_spi_master #(
    .DW(DW),
    .RX(RX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_complete(spi_complete),
    .spi_rx_data (spi_rx_data),
    .spi_rx_valid(spi_rx_valid),
    .spi_sck     (spi_sck),
    .spi_csn     (spi_csn),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: index of the bit currently on miso within the reply frame.
  logic [DW-1:0] slave_reply;
  int            s_idx = 0;
  always @(negedge spi_sck or posedge spi_csn) begin
    if (spi_csn) s_idx <= 0;
    else         s_idx <= s_idx + 1;
  end
  assign spi_miso = (s_idx < int'(DW)) ? slave_reply[DW-1-s_idx] : 1'b0;

  // Line monitor: mosi as seen at each rising sck, and a running pulse count.
  logic [DW-1:0] mosi_cap;
  int            sck_cnt = 0;
  always @(posedge spi_sck) begin
    mosi_cap <= {mosi_cap[DW-2:0], spi_mosi};
    sck_cnt  <= sck_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Per-frame observations; k counts cycles after the accept cycle T.
  int            complete_at[2];
  int            complete_cnt;
  int            rx_valid_at;
  int            rx_valid_cnt;
  int            csn_low_cnt;
  int            csn_fall2_at;
  int            frame_sck;
  logic          csn_after_rst;
  logic [RX-1:0] rx_at_done;

  task automatic run_frame(input logic [DW-1:0] frame, input int ncyc, input int hold_until,
                           input int extra_start_at, input int rst_at);
    int   sck_base;
    logic csn_prev;
    complete_cnt   = 0;
    complete_at[0] = -1;
    complete_at[1] = -1;
    rx_valid_at    = -1;
    rx_valid_cnt   = 0;
    csn_low_cnt    = 0;
    csn_fall2_at   = -1;
    csn_after_rst  = 1'b0;
    rx_at_done     = '0;
    sck_base       = sck_cnt;
    spi_tx_data    = frame;
    spi_start      = 1'b1;
    @(posedge clk);
    #1;
    csn_prev = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      spi_start = (k < hold_until) || (k == extra_start_at);
      rst       = (k == rst_at);
      if (spi_complete) begin
        if (complete_cnt < 2) complete_at[complete_cnt] = k;
        complete_cnt++;
      end
      if (spi_rx_valid) begin
        rx_valid_cnt++;
        rx_valid_at = k;
      end
      if (k == 56) rx_at_done = spi_rx_data;
      if (!spi_csn) csn_low_cnt++;
      if (csn_prev && !spi_csn && csn_fall2_at < 0) csn_fall2_at = k;
      if (rst_at > 0 && k == rst_at + 1) csn_after_rst = spi_csn;
      csn_prev = spi_csn;
    end
    spi_start = 1'b0;
    rst       = 1'b0;
    frame_sck = sck_cnt - sck_base;
  endtask

  logic [DW-1:0] frame;

  initial begin
    rst         = 1'b1;
    spi_start   = 1'b0;
    spi_tx_data = '0;
    slave_reply = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_csn", 32'(spi_csn), 32'd1);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_complete", 32'(spi_complete), 32'd0);
    chk("rst_rx_valid", 32'(spi_rx_valid), 32'd0);
    chk("rst_rx_data", 32'(spi_rx_data), 32'd0);

    // Reset and start together: reset wins, no frame.
    rst       = 1'b1;
    spi_start = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    spi_start = 1'b0;
    chk("rst_vs_start_csn0", 32'(spi_csn), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_vs_start_csn1", 32'(spi_csn), 32'd1);

    // Write, data = 1. Slave replies all ones to show writes leave rx_data alone.
    slave_reply = '1;
    frame = {CMD_WR, 6'd0, 1'b0, 18'h00001};
    run_frame(frame, 60, 0, 0, 0);
    chk("wr1_mosi", 32'(mosi_cap), 32'h4000001);
    chk("wr1_sck_pulses", 32'(frame_sck), 32'd27);
    chk("wr1_complete_at", 32'(complete_at[0]), 32'd56);
    chk("wr1_complete_cnt", 32'(complete_cnt), 32'd1);
    chk("wr1_rx_valid_cnt", 32'(rx_valid_cnt), 32'd0);
    chk("wr1_csn_low", 32'(csn_low_cnt), 32'd55);
    chk("wr1_rx_data", 32'(spi_rx_data), 32'd0);

    // Write, data MSB set: frame bit 9 is the first data bit.
    frame = {CMD_WR, 6'd0, 1'b0, 18'h20001};
    run_frame(frame, 60, 0, 0, 0);
    chk("wr2_mosi", 32'(mosi_cap), 32'h4020001);
    chk("wr2_sck_pulses", 32'(frame_sck), 32'd27);
    chk("wr2_complete_at", 32'(complete_at[0]), 32'd56);
    chk("wr2_complete_cnt", 32'(complete_cnt), 32'd1);
    chk("wr2_rx_valid_cnt", 32'(rx_valid_cnt), 32'd0);

    // Read from address 5; slave returns 18'h2A5A5 in the trailing bits.
    slave_reply = {9'd0, 18'h2A5A5};
    frame = {CMD_RD, 6'd5, 1'b0, 18'h00000};
    run_frame(frame, 60, 0, 0, 0);
    chk("rd_mosi", 32'(mosi_cap), 32'h2280000);
    chk("rd_complete_at", 32'(complete_at[0]), 32'd56);
    chk("rd_rx_valid_at", 32'(rx_valid_at), 32'd56);
    chk("rd_rx_valid_cnt", 32'(rx_valid_cnt), 32'd1);
    chk("rd_rx_data_done", 32'(rx_at_done), 32'h2A5A5);
    chk("rd_rx_data_held", 32'(spi_rx_data), 32'h2A5A5);

    // cmd 2'b11 behaves as a write: rx_data keeps the previous read value.
    slave_reply = '0;
    frame = {2'b11, 6'd63, 1'b0, 18'h3FFFF};
    run_frame(frame, 60, 0, 0, 0);
    chk("cmd11_mosi", 32'(mosi_cap), 32'h7FBFFFF);
    chk("cmd11_rx_valid_cnt", 32'(rx_valid_cnt), 32'd0);
    chk("cmd11_rx_data", 32'(spi_rx_data), 32'h2A5A5);

    // A start pulse mid-frame is dropped, not queued.
    frame = {CMD_WR, 6'd3, 1'b0, 18'h15555};
    run_frame(frame, 60, 0, 10, 0);
    chk("extra_complete_at", 32'(complete_at[0]), 32'd56);
    chk("extra_complete_cnt", 32'(complete_cnt), 32'd1);
    chk("extra_csn_low", 32'(csn_low_cnt), 32'd55);

    // Reset mid-frame during a read.
    slave_reply = {9'd0, 18'h3FFFF};
    frame = {CMD_RD, 6'd1, 1'b0, 18'h00000};
    run_frame(frame, 60, 0, 0, 30);
    chk("midrst_csn_next", 32'(csn_after_rst), 32'd1);
    chk("midrst_complete_cnt", 32'(complete_cnt), 32'd0);
    chk("midrst_rx_valid_cnt", 32'(rx_valid_cnt), 32'd0);
    chk("midrst_rx_data", 32'(spi_rx_data), 32'd0);
    chk("midrst_csn_low", 32'(csn_low_cnt), 32'd30);
    chk("midrst_sck_pulses", 32'(frame_sck), 32'd15);
    chk("midrst_sck_idle", 32'(spi_sck), 32'd0);

    // Start held high across two frames: back to back with one idle cycle.
    frame = {CMD_WR, 6'd9, 1'b0, 18'h0F0F0};
    run_frame(frame, 116, 60, 0, 0);
    chk("b2b_complete1_at", 32'(complete_at[0]), 32'd56);
    chk("b2b_csn_fall2_at", 32'(csn_fall2_at), 32'd58);
    chk("b2b_complete2_at", 32'(complete_at[1]), 32'd113);
    chk("b2b_complete_cnt", 32'(complete_cnt), 32'd2);
    chk("b2b_sck_pulses", 32'(frame_sck), 32'd54);
    chk("b2b_csn_low", 32'(csn_low_cnt), 32'd110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
